travel_plan_seq: RTL and testbench

- Sequencer between the UART command receiver and the heading/motor datapath of the maze runner.
- Latches a 16-bit travel plan (eight 2-bit maneuvers, LSB pair first), enables forward motion and tracks line gaps.
- At each debounced gap it applies the next maneuver as a desired-heading offset, then waits for the line to reappear.
- Stops on a stop code, on plan exhaustion, or on a bump; drives the buzzer enable.

---
 rtl/travel_plan_seq_pkg.sv | 44 ++++
 rtl/travel_plan_seq_if.sv | 26 ++
 rtl/travel_plan_seq_line_debounce.sv | 28 ++
 rtl/travel_plan_seq.sv | 141 ++++++++++++++
 tb/tb_travel_plan_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/travel_plan_seq_pkg.sv
// Shared types and constants for the maze runner travel-plan sequencer.
// Holds the maneuver/state encodings and the heading-offset helper.
package maze_pkg;

    typedef enum logic [1:0] {
        MNV_STOP  = 2'b00,
        MNV_RIGHT = 2'b01,
        MNV_LEFT  = 2'b10,
        MNV_TURN  = 2'b11
    } mnv_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_MANEUVER,
        ST_REACQ,
        ST_BUMP
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int HDG_W        = 12;
    localparam int PLAN_LEN     = 8;
    localparam int VEER_OFF_DEF = 350;
    localparam int TURN_OFF_DEF = 1800;

    // Signed heading delta for one maneuver; the caller adds it modulo 2^HDG_W.
    function automatic logic signed [HDG_W-1:0] hdg_step(input mnv_e mnv, input dir_e dir,
                                                         input int veer, input int turn);
        logic signed [HDG_W-1:0] step;
        step = '0;
        case (mnv)
            MNV_RIGHT: step = HDG_W'(veer);
            MNV_LEFT:  step = HDG_W'(-veer);
            MNV_TURN:  step = (dir == DIR_RIGHT) ? HDG_W'(turn) : HDG_W'(-turn);
            default:   step = '0;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/travel_plan_seq_if.sv
// Command, sensor and motion-control signals between the sequencer and its neighbours.
interface travel_plan_seq_if;
    import maze_pkg::*;

    logic [15:0]             cmd;
    logic                    cmd_rdy;
    logic                    clr_cmd_rdy;
    logic                    line_present;
    logic                    BMPL_n;
    logic                    BMPR_n;
    logic                    go;
    logic signed [HDG_W-1:0] dsrd_hdg;
    logic                    buzz_en;
    logic                    plan_done;

    modport master (
        output cmd, cmd_rdy, line_present, BMPL_n, BMPR_n,
        input  clr_cmd_rdy, go, dsrd_hdg, buzz_en, plan_done
    );

    modport slave (
        input  cmd, cmd_rdy, line_present, BMPL_n, BMPR_n,
        output clr_cmd_rdy, go, dsrd_hdg, buzz_en, plan_done
    );

endinterface

// File: rtl/travel_plan_seq_line_debounce.sv
// Consecutive-sample counter: o_tc fires on the N-th consecutive enabled sample.
module line_debounce #(
    parameter int N = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(N - 1));
    assign o_tc   = i_en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr || o_tc)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/travel_plan_seq.sv
// Travel-plan sequencer: steps through eight 2-bit maneuvers, one per debounced line gap,
// steering by desired-heading offsets and stopping on a stop code, plan end or bump.
module travel_plan_seq
    import maze_pkg::*;
#(
    parameter int GAP_CYC   = 4096,
    parameter int REACQ_CYC = 4096,
    parameter int VEER_OFF  = VEER_OFF_DEF,
    parameter int TURN_OFF  = TURN_OFF_DEF
) (
    input  logic              clk,
    input  logic              rst,
    travel_plan_seq_if.slave  bus
);
    state_e                  r_state, w_state_nxt;
    logic [15:0]             r_sr, w_sr_nxt;
    logic [3:0]              r_cnt, w_cnt_nxt;
    dir_e                    r_dir, w_dir_nxt;
    logic                    r_go, w_go_nxt;
    logic                    r_buzz, w_buzz_nxt;
    logic                    r_done, w_done_nxt;
    logic signed [HDG_W-1:0] r_hdg, w_hdg_nxt;

    logic w_bump, w_load, w_gap_tc, w_reacq_tc;
    mnv_e w_mnv;

    assign w_bump = !bus.BMPL_n || !bus.BMPR_n;
    assign w_load = ((r_state == ST_IDLE) || (r_state == ST_BUMP)) && bus.cmd_rdy;
    assign w_mnv  = mnv_e'(r_sr[1:0]);

    line_debounce #(.N(GAP_CYC)) u_gap (
        .clk   (clk),
        .rst   (rst),
        .i_en  ((r_state == ST_FOLLOW) && !bus.line_present),
        .i_clr ((r_state != ST_FOLLOW) || bus.line_present),
        .o_tc  (w_gap_tc)
    );

    line_debounce #(.N(REACQ_CYC)) u_reacq (
        .clk   (clk),
        .rst   (rst),
        .i_en  ((r_state == ST_REACQ) && bus.line_present),
        .i_clr ((r_state != ST_REACQ) || !bus.line_present),
        .o_tc  (w_reacq_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_LEFT;
            r_go    <= 1'b0;
            r_buzz  <= 1'b0;
            r_done  <= 1'b0;
            r_hdg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_go    <= w_go_nxt;
            r_buzz  <= w_buzz_nxt;
            r_done  <= w_done_nxt;
            r_hdg   <= w_hdg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_go_nxt    = r_go;
        w_buzz_nxt  = r_buzz;
        w_done_nxt  = r_done;
        w_hdg_nxt   = r_hdg;

        if (w_load) begin
            w_state_nxt = ST_FOLLOW;
            w_sr_nxt    = bus.cmd;
            w_cnt_nxt   = '0;
            w_dir_nxt   = DIR_LEFT;
            w_go_nxt    = 1'b1;
            w_buzz_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_hdg_nxt   = '0;
        end else if ((r_state != ST_IDLE) && w_bump) begin
            // A bump overrides whatever the plan was about to do.
            w_state_nxt = ST_BUMP;
            w_go_nxt    = 1'b0;
            w_buzz_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_FOLLOW: begin
                    if (w_gap_tc)
                        w_state_nxt = ST_MANEUVER;
                end
                ST_MANEUVER: begin
                    if (w_mnv == MNV_STOP) begin
                        w_go_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_hdg_nxt   = r_hdg + hdg_step(w_mnv, r_dir, VEER_OFF, TURN_OFF);
                        w_buzz_nxt  = (w_mnv == MNV_TURN);
                        if (w_mnv == MNV_RIGHT)
                            w_dir_nxt = DIR_RIGHT;
                        else if (w_mnv == MNV_LEFT)
                            w_dir_nxt = DIR_LEFT;
                        w_state_nxt = ST_REACQ;
                    end
                end
                ST_REACQ: begin
                    if (w_reacq_tc) begin
                        w_sr_nxt   = r_sr >> 2;
                        w_cnt_nxt  = r_cnt + 4'd1;
                        w_buzz_nxt = 1'b0;
                        if (w_cnt_nxt == 4'(PLAN_LEN)) begin
                            w_go_nxt    = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_FOLLOW;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The acknowledge is combinational so it lands in the same cycle the plan is latched.
    assign bus.clr_cmd_rdy = w_load && !rst;
    assign bus.go          = r_go;
    assign bus.dsrd_hdg    = r_hdg;
    assign bus.buzz_en     = r_buzz;
    assign bus.plan_done   = r_done;

endmodule

// File: tb/tb_travel_plan_seq.sv
// Directed bench for travel_plan_seq with shortened gap/reacquire windows.
module tb_travel_plan_seq;
    import maze_pkg::*;

    localparam int GAP   = 16;
    localparam int REACQ = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   clr_cnt;

    travel_plan_seq_if bus();

    travel_plan_seq #(
        .GAP_CYC   (GAP),
        .REACQ_CYC (REACQ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)
            clr_cnt <= 0;
        else if (bus.clr_cmd_rdy)
            clr_cnt <= clr_cnt + 1;
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected heading is reduced to its 12-bit two's-complement pattern.
    task automatic chk_hdg(input string tag, input int exp);
        logic [11:0] e;
        logic [11:0] g;
        e = 12'(exp);
        g = bus.dsrd_hdg;
        n_tests++;
        assert (g === e) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, g, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic send_cmd(input logic [15:0] c, input string tag);
        bus.cmd     = c;
        bus.cmd_rdy = 1'b1;
        #1;
        chk1(tag, bus.clr_cmd_rdy, 1'b1);
        tick(1);
        bus.cmd_rdy = 1'b0;
    endtask

    task automatic gap(input int n);
        bus.line_present = 1'b0;
        tick(n);
        bus.line_present = 1'b1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.cmd          = '0;
        bus.cmd_rdy      = 1'b0;
        bus.line_present = 1'b1;
        bus.BMPL_n       = 1'b1;
        bus.BMPR_n       = 1'b1;
        tick(3);
        chk1("rst_go", bus.go, 1'b0);
        chk_hdg("rst_hdg", 0);
        chk1("rst_buzz", bus.buzz_en, 1'b0);
        chk1("rst_done", bus.plan_done, 1'b0);
        chk1("rst_clr", bus.clr_cmd_rdy, 1'b0);
        rst = 1'b0;
        tick(1);

        // Veer-right plan run to exhaustion; pending cmd_rdy mid-plan is not acknowledged.
        send_cmd(16'h5555, "t1_ack");
        chk1("t1_go", bus.go, 1'b1);
        tick(20);
        chk_hdg("t1_steady", 0);
        gap(GAP);
        chk_hdg("t1_mnv_cycle", 0);
        tick(1);
        chk_hdg("t1_hdg1", 350);
        chk1("t1_buzz", bus.buzz_en, 1'b0);
        bus.cmd     = 16'h0000;
        bus.cmd_rdy = 1'b1;
        #1;
        chk1("t1_no_ack", bus.clr_cmd_rdy, 1'b0);
        bus.cmd_rdy = 1'b0;
        tick(REACQ);
        gap(GAP);
        tick(1);
        chk_hdg("t1_hdg2", 700);
        for (int i = 3; i <= 8; i++) begin
            tick(REACQ);
            gap(GAP);
            tick(1);
        end
        chk_hdg("t1_hdg8_wrap", 2800);
        chk1("t1_go_before_end", bus.go, 1'b1);
        tick(REACQ);
        chk1("t1_end_go", bus.go, 1'b0);
        chk1("t1_end_done", bus.plan_done, 1'b1);

        // Turn-around with initial last_dir LEFT; buzzer held through reacquire.
        do_reset();
        send_cmd(16'hFFFF, "t2_ack");
        gap(GAP);
        tick(1);
        chk_hdg("t2_hdg", -1800);
        chk1("t2_buzz_on", bus.buzz_en, 1'b1);
        tick(REACQ - 1);
        chk1("t2_buzz_hold", bus.buzz_en, 1'b1);
        tick(1);
        chk1("t2_buzz_off", bus.buzz_en, 1'b0);
        chk1("t2_go", bus.go, 1'b1);

        // Right veer, turn (goes right, wraps), left veer, then stop code.
        do_reset();
        send_cmd(16'h002D, "t3_ack");
        gap(GAP);
        tick(1);
        chk_hdg("t3_hdg1", 350);
        tick(REACQ);
        gap(GAP);
        tick(1);
        chk_hdg("t3_hdg2_wrap", 2150);
        chk1("t3_buzz_turn", bus.buzz_en, 1'b1);
        tick(REACQ);
        gap(GAP);
        tick(1);
        chk_hdg("t3_hdg3", 1800);
        chk1("t3_buzz_veer", bus.buzz_en, 1'b0);
        tick(REACQ);
        gap(GAP);
        tick(1);
        chk1("t3_stop_go", bus.go, 1'b0);
        chk1("t3_stop_done", bus.plan_done, 1'b1);
        chk_hdg("t3_stop_hdg", 1800);
        chk_int("t3_clr_count", clr_cnt, 1);

        // One-short dropout is a glitch; a full-length one is a gap.
        do_reset();
        send_cmd(16'hAAAA, "t4_ack");
        gap(GAP - 1);
        tick(3);
        chk_hdg("t4_glitch", 0);
        chk1("t4_go", bus.go, 1'b1);
        gap(GAP);
        tick(1);
        chk_hdg("t4_hdg", -350);

        // Bump during FOLLOW, then restart from BUMP.
        do_reset();
        send_cmd(16'h5555, "t5_ack1");
        gap(GAP);
        tick(1);
        chk_hdg("t5_hdg", 350);
        tick(REACQ);
        tick(5);
        bus.BMPL_n = 1'b0;
        tick(1);
        bus.BMPL_n = 1'b1;
        chk1("t5_bump_go", bus.go, 1'b0);
        chk1("t5_bump_buzz", bus.buzz_en, 1'b1);
        chk1("t5_bump_done", bus.plan_done, 1'b1);
        tick(3);
        chk1("t5_bump_hold", bus.buzz_en, 1'b1);
        send_cmd(16'h5555, "t5_ack2");
        chk1("t5_restart_go", bus.go, 1'b1);
        chk1("t5_restart_buzz", bus.buzz_en, 1'b0);
        chk_hdg("t5_restart_hdg", 0);
        chk1("t5_restart_done", bus.plan_done, 1'b0);

        // Asynchronous reset in the middle of a turn-around reacquire.
        do_reset();
        send_cmd(16'hFFFF, "t6_ack1");
        gap(GAP);
        tick(4);
        chk1("t6_pre_buzz", bus.buzz_en, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t6_rst_go", bus.go, 1'b0);
        chk1("t6_rst_buzz", bus.buzz_en, 1'b0);
        chk_hdg("t6_rst_hdg", 0);
        chk1("t6_rst_done", bus.plan_done, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(1);
        send_cmd(16'hFFFF, "t6_ack2");
        chk1("t6_go", bus.go, 1'b1);
        chk_hdg("t6_hdg0", 0);
        gap(GAP);
        tick(1);
        chk_hdg("t6_hdg", -1800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
